// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and shared types for the
// multi-port register file (option: REGFILE_BYPASS_EN)
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NR_DEF     = 2;
  localparam int NW_DEF     = 1;
  localparam int AW_DEF     = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, writeback and issue signals
// between the issue stage (master) and regfile (slave)
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NR     = NR_DEF,
  parameter int NW     = NW_DEF
);

  localparam int AW = $clog2(DEPTH);

  logic [NR*AW-1:0]     rs_addr_i;
  logic [NR*DATA_W-1:0] rs_data_o;
  logic [NR-1:0]        rs_busy_o;
  logic [NW*AW-1:0]     rd_addr_i;
  logic [NW*DATA_W-1:0] rd_data_i;
  logic [NW-1:0]        rd_wren_i;
  logic                 issue_valid_i;
  logic [AW-1:0]        issue_rd_i;
  logic                 flush_i;

  modport master (
    output rs_addr_i, rd_addr_i, rd_data_i,
    output rd_wren_i, issue_valid_i,
    output issue_rd_i, flush_i,
    input  rs_data_o, rs_busy_o
  );

  modport slave (
    input  rs_addr_i, rd_addr_i, rd_data_i,
    input  rd_wren_i, issue_valid_i,
    input  issue_rd_i, flush_i,
    output rs_data_o, rs_busy_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with
// flush > issue > writeback-clear priority
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int NR    = NR_DEF,
  parameter int NW    = NW_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           issue_valid_i,
  input  logic [AW-1:0]  issue_rd_i,
  input  logic           flush_i,
  input  logic [NW*AW-1:0] rd_addr_i,
  input  logic [NW-1:0]  rd_wren_i,
  input  logic [NR*AW-1:0] rs_addr_i,
  output logic [NR-1:0]  rs_busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // writebacks clear, a newer issue re-sets, flush wipes
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (rd_wren_i[j])
        busy_d[rd_addr_i[j*AW +: AW]] = 1'b0;
    end
    if (issue_valid_i)
      busy_d[issue_rd_i] = 1'b1;
    if (flush_i)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // busy state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  // per-port busy lookup, registered state only
  always_comb begin
    rs_busy_o = '0;
    for (int k = 0; k < NR; k++)
      rs_busy_o[k] = busy_q[rs_addr_i[k*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, x0 hardwired
// to zero; REGFILE_BYPASS_EN adds write-to-read forwarding
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NR     = NR_DEF,
  parameter int NW     = NW_DEF
) (
  input logic         clk_i,
  input logic         rst_ni,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [NR-1:0]     sb_busy;

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NR    (NR),
    .NW    (NW)
  ) u_sb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_valid_i (bus.issue_valid_i),
    .issue_rd_i    (bus.issue_rd_i),
    .flush_i       (bus.flush_i),
    .rd_addr_i     (bus.rd_addr_i),
    .rd_wren_i     (bus.rd_wren_i),
    .rs_addr_i     (bus.rs_addr_i),
    .rs_busy_o     (sb_busy)
  );

  // storage; later ports overwrite earlier on collision
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (bus.rd_wren_i[j] &&
            bus.rd_addr_i[j*AW +: AW] != '0)
          regs_q[bus.rd_addr_i[j*AW +: AW]] <=
            bus.rd_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  // read ports; reset and x0 force zero over forwarding
  always_comb begin
    bus.rs_data_o = '0;
    bus.rs_busy_o = '0;
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rdat;
      logic              rbsy;
      ra   = bus.rs_addr_i[k*AW +: AW];
      rdat = regs_q[ra];
      rbsy = sb_busy[k];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NW; j++) begin
        if (bus.rd_wren_i[j] &&
            bus.rd_addr_i[j*AW +: AW] != '0 &&
            bus.rd_addr_i[j*AW +: AW] == ra) begin
          rdat = bus.rd_data_i[j*DATA_W +: DATA_W];
          if (!(bus.issue_valid_i &&
                bus.issue_rd_i == ra))
            rbsy = 1'b0;
        end
      end
`endif
      if (!rst_ni || ra == '0) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      bus.rs_data_o[k*DATA_W +: DATA_W] = rdat;
      bus.rs_busy_o[k] = rbsy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, corner sequences and
// randomized traffic against an array-based model
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(
    .DATA_W (DW), .DEPTH (DEPTH), .NR (NR), .NW (NW)
  ) bus ();

  regfile_mp #(
    .DATA_W (DW), .DEPTH (DEPTH), .NR (NR), .NW (NW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_busy [DEPTH];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  task automatic idle();
    bus.rd_wren_i     = '0;
    bus.rd_addr_i     = '0;
    bus.rd_data_i     = '0;
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = '0;
    bus.flush_i       = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic bit hit(input logic [AW-1:0] a);
    bit h = 1'b0;
    for (int j = 0; j < NW; j++)
      if (bus.rd_wren_i[j] && a != 0 &&
          bus.rd_addr_i[j*AW +: AW] == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [DW-1:0] exp_data(
      input logic [AW-1:0] a);
    logic [DW-1:0] v = m_reg[a];
    if (BYP)
      for (int j = 0; j < NW; j++)
        if (bus.rd_wren_i[j] && a != 0 &&
            bus.rd_addr_i[j*AW +: AW] == a)
          v = bus.rd_data_i[j*DW +: DW];
    if (a == 0 || !rst_ni) v = '0;
    return v;
  endfunction

  function automatic logic exp_busy(
      input logic [AW-1:0] a);
    logic b = m_busy[a];
    if (BYP && hit(a) &&
        !(bus.issue_valid_i && bus.issue_rd_i == a))
      b = 1'b0;
    if (!rst_ni) b = 1'b0;
    return b;
  endfunction

  task automatic check_ports(input string tag);
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      a = bus.rs_addr_i[k*AW +: AW];
      chk($sformatf("%s_d%0d_x%0d", tag, k, a),
          bus.rs_data_o[k*DW +: DW], exp_data(a));
      chk($sformatf("%s_b%0d_x%0d", tag, k, a),
          {31'd0, bus.rs_busy_o[k]}, {31'd0, exp_busy(a)});
    end
  endtask

  // apply the driven inputs to the model, then clock
  task automatic tick();
    for (int j = 0; j < NW; j++) begin
      logic [AW-1:0] a;
      a = bus.rd_addr_i[j*AW +: AW];
      if (bus.rd_wren_i[j] && a != 0)
        m_reg[a] = bus.rd_data_i[j*DW +: DW];
    end
    if (bus.flush_i) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (bus.rd_wren_i[j])
          m_busy[bus.rd_addr_i[j*AW +: AW]] = 1'b0;
      if (bus.issue_valid_i && bus.issue_rd_i != 0)
        m_busy[bus.issue_rd_i] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
               1'b0, 5'd0, 1'b0, 5'd5, 5'd0,
               32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tv[1]  = '{2'b01, 5'd0, 5'd0, 32'h1234, 32'h0,
               1'b0, 5'd0, 1'b0, 5'd0, 5'd5,
               32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[2]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22,
               1'b0, 5'd0, 1'b0, 5'd7, 5'd5,
               32'h22, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b1, 5'd9, 1'b0, 5'd9, 5'd7,
               32'h0, 32'h22, 1'b1, 1'b0};
    tv[4]  = '{2'b01, 5'd9, 5'd0, 32'hAAAA, 32'h0,
               1'b1, 5'd9, 1'b0, 5'd9, 5'd7,
               32'hAAAA, 32'h22, 1'b1, 1'b0};
    tv[5]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'hBBBB,
               1'b0, 5'd0, 1'b0, 5'd9, 5'd7,
               32'hBBBB, 32'h22, 1'b0, 1'b0};
    tv[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b1, 5'd0, 1'b0, 5'd0, 5'd9,
               32'h0, 32'hBBBB, 1'b0, 1'b0};
    tv[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b1, 5'd3, 1'b0, 5'd3, 5'd4,
               32'h0, 32'h0, 1'b1, 1'b0};
    tv[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b1, 5'd4, 1'b0, 5'd3, 5'd4,
               32'h0, 32'h0, 1'b1, 1'b1};
    tv[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b1, 5'd6, 1'b1, 5'd6, 5'd3,
               32'h0, 32'h0, 1'b0, 1'b0};
    tv[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
               1'b0, 5'd0, 1'b0, 5'd4, 5'd6,
               32'h0, 32'h0, 1'b0, 1'b0};
    tv[11] = '{2'b10, 5'd0, 5'd12, 32'h0, 32'h5,
               1'b0, 5'd0, 1'b0, 5'd12, 5'd9,
               32'h5, 32'hBBBB, 1'b0, 1'b0};

    // reset dominates writes and issues driven during it
    model_reset();
    idle();
    bus.rd_wren_i     = 2'b11;
    bus.rd_addr_i     = {5'd3, 5'd3};
    bus.rd_data_i     = {32'h55, 32'h66};
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd3;
    bus.rs_addr_i     = {5'd3, 5'd3};
    repeat (2) @(negedge clk);
    chk("in_rst_data", bus.rs_data_o[31:0], 32'h0);
    chk("in_rst_busy", {30'd0, bus.rs_busy_o}, 32'h0);
    idle();
    rst_ni = 1'b1;

    // every address on both ports reads zero, not busy
    for (int i = 0; i < DEPTH; i++) begin
      bus.rs_addr_i = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("rst_d0_x%0d", i),
          bus.rs_data_o[31:0], 32'h0);
      chk($sformatf("rst_d1_x%0d", 31 - i),
          bus.rs_data_o[63:32], 32'h0);
      chk($sformatf("rst_b_x%0d", i),
          {30'd0, bus.rs_busy_o}, 32'h0);
    end

    // directed table
    for (int i = 0; i < 12; i++) begin
      idle();
      bus.rd_wren_i     = tv[i].we;
      bus.rd_addr_i     = {tv[i].wa1, tv[i].wa0};
      bus.rd_data_i     = {tv[i].wd1, tv[i].wd0};
      bus.issue_valid_i = tv[i].iv;
      bus.issue_rd_i    = tv[i].ird;
      bus.flush_i       = tv[i].fl;
      tick();
      idle();
      bus.rs_addr_i = {tv[i].ra1, tv[i].ra0};
      #1;
      chk($sformatf("tv%0d_d0", i),
          bus.rs_data_o[31:0], tv[i].ed0);
      chk($sformatf("tv%0d_d1", i),
          bus.rs_data_o[63:32], tv[i].ed1);
      chk($sformatf("tv%0d_b0", i),
          {31'd0, bus.rs_busy_o[0]}, {31'd0, tv[i].eb0});
      chk($sformatf("tv%0d_b1", i),
          {31'd0, bus.rs_busy_o[1]}, {31'd0, tv[i].eb1});
    end

    // same-cycle write/read of x10
    idle();
    bus.rd_wren_i = 2'b01;
    bus.rd_addr_i = {5'd0, 5'd10};
    bus.rd_data_i = {32'h0, 32'h1111};
    tick();
    bus.rd_wren_i = 2'b10;
    bus.rd_addr_i = {5'd10, 5'd0};
    bus.rd_data_i = {32'hCAFE, 32'h0};
    bus.rs_addr_i = {5'd10, 5'd10};
    #1;
    chk("byp_same", bus.rs_data_o[31:0],
        BYP ? 32'hCAFE : 32'h1111);
    check_ports("byp");
    tick();
    idle();
    #1;
    chk("byp_next", bus.rs_data_o[31:0], 32'hCAFE);

    // async reset lands in the middle of a write
    bus.rd_wren_i = 2'b01;
    bus.rd_addr_i = {5'd0, 5'd10};
    bus.rd_data_i = {32'h0, 32'hBEEF};
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_now", bus.rs_data_o[31:0], 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_ni = 1'b1;
    #1;
    chk("arst_after", bus.rs_data_o[31:0], 32'h0);
    tick();
    check_ports("arst_post");

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      bus.rd_wren_i = 2'($urandom_range(0, 3));
      bus.rd_addr_i = {5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7))};
      bus.rd_data_i = {$urandom, $urandom};
      bus.issue_valid_i = 1'($urandom_range(0, 1));
      bus.issue_rd_i    = 5'($urandom_range(0, 7));
      bus.flush_i = ($urandom_range(0, 15) == 0);
      bus.rs_addr_i = {5'($urandom_range(0, 9)),
                       5'($urandom_range(0, 31))};
      #1;
      check_ports($sformatf("rnd%0d", c));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
